// File: rtl/mem_arbiter.sv
// Two-master (fetch / load-store) arbiter onto a single memory port.
// One transaction in flight at a time; round-robin on ties.
module mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst,

    input  logic                ifu_req_valid,
    output logic                ifu_req_ready,
    input  logic [ADDR_W-1:0]   ifu_addr,
    output logic                ifu_resp_valid,
    input  logic                ifu_resp_ready,
    output logic [DATA_W-1:0]   ifu_rdata,

    input  logic                lsu_req_valid,
    output logic                lsu_req_ready,
    input  logic [ADDR_W-1:0]   lsu_addr,
    input  logic                lsu_wen,
    input  logic [DATA_W-1:0]   lsu_wdata,
    input  logic [DATA_W/8-1:0] lsu_wmask,
    output logic                lsu_resp_valid,
    input  logic                lsu_resp_ready,
    output logic [DATA_W-1:0]   lsu_rdata,

    output logic                mem_req_valid,
    input  logic                mem_req_ready,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic                mem_wen,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_wmask,
    input  logic                mem_resp_valid,
    output logic                mem_resp_ready,
    input  logic [DATA_W-1:0]   mem_rdata
);

    localparam int MASK_W = DATA_W / 8;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_RESP
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic                r_owner;
    logic                r_last;
    logic [ADDR_W-1:0]   r_addr;
    logic                r_wen;
    logic [DATA_W-1:0]   r_wdata;
    logic [MASK_W-1:0]   r_wmask;

    logic                w_grant_ifu;
    logic                w_grant_lsu;
    logic                w_owner_resp_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_owner <= 1'b0;
            r_last  <= 1'b1;
            r_addr  <= '0;
            r_wen   <= 1'b0;
            r_wdata <= '0;
            r_wmask <= '0;
        end else begin
            r_state <= w_next;
            if (w_grant_ifu) begin
                r_owner <= 1'b0;
                r_last  <= 1'b0;
                r_addr  <= ifu_addr;
                r_wen   <= 1'b0;
                r_wdata <= '0;
                r_wmask <= '0;
            end else if (w_grant_lsu) begin
                r_owner <= 1'b1;
                r_last  <= 1'b1;
                r_addr  <= lsu_addr;
                r_wen   <= lsu_wen;
                r_wdata <= lsu_wdata;
                r_wmask <= lsu_wmask;
            end
        end
    end

    always_comb begin
        w_grant_ifu        = 1'b0;
        w_grant_lsu        = 1'b0;
        w_owner_resp_ready = r_owner ? lsu_resp_ready : ifu_resp_ready;
        w_next             = r_state;

        ifu_req_ready  = 1'b0;
        lsu_req_ready  = 1'b0;
        ifu_resp_valid = 1'b0;
        ifu_rdata      = '0;
        lsu_resp_valid = 1'b0;
        lsu_rdata      = '0;
        mem_req_valid  = 1'b0;
        mem_addr       = '0;
        mem_wen        = 1'b0;
        mem_wdata      = '0;
        mem_wmask      = '0;
        mem_resp_ready = 1'b0;

        case (r_state)
            S_IDLE: begin
                // Readies are combinational from valids, so hold them low while rst is asserted.
                if (!rst) begin
                    if (ifu_req_valid && (!lsu_req_valid || r_last)) begin
                        w_grant_ifu = 1'b1;
                    end else if (lsu_req_valid) begin
                        w_grant_lsu = 1'b1;
                    end
                end
                ifu_req_ready = w_grant_ifu;
                lsu_req_ready = w_grant_lsu;
                if (w_grant_ifu || w_grant_lsu) begin
                    w_next = S_REQ;
                end
            end
            S_REQ: begin
                mem_req_valid = 1'b1;
                mem_addr      = r_addr;
                mem_wen       = r_wen;
                mem_wdata     = r_wdata;
                mem_wmask     = r_wmask;
                if (mem_req_ready) begin
                    w_next = S_RESP;
                end
            end
            S_RESP: begin
                mem_resp_ready = w_owner_resp_ready;
                if (r_owner) begin
                    lsu_resp_valid = mem_resp_valid;
                    lsu_rdata      = mem_rdata;
                end else begin
                    ifu_resp_valid = mem_resp_valid;
                    ifu_rdata      = mem_rdata;
                end
                if (mem_resp_valid && w_owner_resp_ready) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized
// transactions checked against a transaction-level round-robin model.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        ifu_req_valid, ifu_req_ready, ifu_resp_valid, ifu_resp_ready;
    logic [31:0] ifu_addr, ifu_rdata;
    logic        lsu_req_valid, lsu_req_ready, lsu_wen, lsu_resp_valid, lsu_resp_ready;
    logic [31:0] lsu_addr, lsu_wdata, lsu_rdata;
    logic [3:0]  lsu_wmask;
    logic        mem_req_valid, mem_req_ready, mem_wen, mem_resp_valid, mem_resp_ready;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_wmask;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;
    logic        m_last  = 1'b1;   // model: 0 = IFU granted last, 1 = LSU

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst(rst),
        .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
        .ifu_resp_valid(ifu_resp_valid), .ifu_resp_ready(ifu_resp_ready), .ifu_rdata(ifu_rdata),
        .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_addr(lsu_addr),
        .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
        .lsu_resp_valid(lsu_resp_valid), .lsu_resp_ready(lsu_resp_ready), .lsu_rdata(lsu_rdata),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
        .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
        .mem_resp_valid(mem_resp_valid), .mem_resp_ready(mem_resp_ready), .mem_rdata(mem_rdata)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs;
        ifu_req_valid = 0; ifu_addr = '0; ifu_resp_ready = 0;
        lsu_req_valid = 0; lsu_addr = '0; lsu_wen = 0; lsu_wdata = '0; lsu_wmask = '0;
        lsu_resp_ready = 0; mem_req_ready = 0; mem_resp_valid = 0; mem_rdata = '0;
    endtask

    // Random master-side activity that the arbiter must ignore outside IDLE.
    task automatic scramble;
        ifu_req_valid  = 1'($urandom_range(0, 1));
        lsu_req_valid  = 1'($urandom_range(0, 1));
        ifu_addr       = $urandom;
        lsu_addr       = $urandom;
        lsu_wen        = 1'($urandom_range(0, 1));
        lsu_wdata      = $urandom;
        lsu_wmask      = 4'($urandom);
        ifu_resp_ready = 1'($urandom_range(0, 1));
        lsu_resp_ready = 1'($urandom_range(0, 1));
        mem_rdata      = $urandom;
    endtask

    // Drives one complete transaction starting in an IDLE cycle and checks every cycle of it.
    task automatic run_txn(input logic iv, input logic lv, input logic [31:0] ia,
                           input logic [31:0] la, input logic lw, input logic [31:0] lwd,
                           input logic [3:0] lm, input int unsigned req_stall,
                           input int unsigned resp_delay, input int unsigned rdy_stall,
                           input logic [31:0] rd);
        logic        g, v, ordy;
        logic [31:0] ea, ed;
        logic        ew;
        logic [3:0]  em;
        ifu_req_valid = iv; lsu_req_valid = lv; ifu_addr = ia; lsu_addr = la;
        lsu_wen = lw; lsu_wdata = lwd; lsu_wmask = lm;
        mem_req_ready = 0; mem_resp_valid = 0;
        #1;
        g = (iv && lv) ? ~m_last : lv;
        if (g) {ea, ew, ed, em} = {la, lw, lwd, lm};
        else   {ea, ew, ed, em} = {ia, 1'b0, 32'h0, 4'h0};
        n_tests++;
        if ({ifu_req_ready, lsu_req_ready} !== {~g, g}) begin
            n_fail++;
            $display("FAIL grant: got ifu/lsu ready %b%b want %b%b", ifu_req_ready, lsu_req_ready, ~g, g);
        end
        m_last = g;
        tick;
        for (int unsigned i = 0; i <= req_stall; i++) begin
            scramble();
            mem_req_ready = (i == req_stall);
            #1;
            n_tests++;
            if ({mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask} !== {1'b1, ea, ew, ed, em}) begin
                n_fail++;
                $display("FAIL mem_req: got v=%b a=%h w=%b d=%h m=%h want v=1 a=%h w=%b d=%h m=%h",
                         mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask, ea, ew, ed, em);
            end
            n_tests++;
            if ({ifu_req_ready, lsu_req_ready, ifu_resp_valid, lsu_resp_valid, mem_resp_ready} !== 5'b0) begin
                n_fail++;
                $display("FAIL req_quiet: got rdy %b%b rv %b%b mrr %b want all 0",
                         ifu_req_ready, lsu_req_ready, ifu_resp_valid, lsu_resp_valid, mem_resp_ready);
            end
            tick;
        end
        mem_req_ready = 0;
        for (int unsigned i = 0; i <= resp_delay + rdy_stall; i++) begin
            scramble();
            v    = (i >= resp_delay);
            ordy = (i < resp_delay) ? 1'($urandom_range(0, 1)) : (i == resp_delay + rdy_stall);
            mem_resp_valid = v;
            if (v) mem_rdata = rd;
            if (g) lsu_resp_ready = ordy; else ifu_resp_ready = ordy;
            #1;
            n_tests++;
            if ({mem_req_valid, ifu_req_ready, lsu_req_ready} !== 3'b0) begin
                n_fail++;
                $display("FAIL resp_quiet: got mrv %b rdy %b%b want 000", mem_req_valid, ifu_req_ready, lsu_req_ready);
            end
            n_tests++;
            if ({ifu_resp_valid, lsu_resp_valid, mem_resp_ready} !== {(g ? 1'b0 : v), (g ? v : 1'b0), ordy}) begin
                n_fail++;
                $display("FAIL resp_route: got ifu_rv %b lsu_rv %b mrr %b want %b %b %b",
                         ifu_resp_valid, lsu_resp_valid, mem_resp_ready, (g ? 1'b0 : v), (g ? v : 1'b0), ordy);
            end
            if (v) begin
                n_tests++;
                if ((g ? lsu_rdata : ifu_rdata) !== rd) begin
                    n_fail++;
                    $display("FAIL rdata: got %h want %h", (g ? lsu_rdata : ifu_rdata), rd);
                end
            end
            tick;
        end
        clear_inputs();
        #1;
        n_tests++;
        if ({mem_req_valid, mem_resp_ready, ifu_resp_valid, lsu_resp_valid, ifu_req_ready, lsu_req_ready} !== 6'b0) begin
            n_fail++;
            $display("FAIL post_idle: got mrv %b mrr %b rv %b%b rdy %b%b want all 0",
                     mem_req_valid, mem_resp_ready, ifu_resp_valid, lsu_resp_valid, ifu_req_ready, lsu_req_ready);
        end
    endtask

    task automatic test_reset;
        clear_inputs();
        rst = 1;
        tick;
        tick;
        ifu_req_valid = 1; lsu_req_valid = 1; ifu_addr = 32'h1234_5678; lsu_addr = 32'h9abc_def0;
        #1;
        n_tests++;
        if ({ifu_req_ready, lsu_req_ready, mem_req_valid, mem_resp_ready, ifu_resp_valid, lsu_resp_valid} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got rdy %b%b mrv %b mrr %b rv %b%b want all 0",
                     ifu_req_ready, lsu_req_ready, mem_req_valid, mem_resp_ready, ifu_resp_valid, lsu_resp_valid);
        end
        n_tests++;
        if ({mem_addr, mem_wen, mem_wdata, mem_wmask, ifu_rdata, lsu_rdata} !== '0) begin
            n_fail++;
            $display("FAIL reset_data: got a=%h w=%b d=%h m=%h ird=%h lrd=%h want 0",
                     mem_addr, mem_wen, mem_wdata, mem_wmask, ifu_rdata, lsu_rdata);
        end
        clear_inputs();
        rst = 0;
        m_last = 1'b1;
        tick;
    endtask

    task automatic test_single_fetch;
        run_txn(1, 0, 32'h8000_0000, 32'h0, 0, 32'h0, 4'h0, 0, 2, 0, 32'h0000_0413);
    endtask

    task automatic test_round_robin;
        rst = 1;
        tick;
        rst = 0;
        m_last = 1'b1;
        for (int unsigned k = 0; k < 3; k++)
            run_txn(1, 1, $urandom, $urandom, 1, $urandom, 4'($urandom), 0, 1, 0, $urandom);
    endtask

    task automatic test_store_stall;
        run_txn(0, 1, 32'h0, 32'h8000_1000, 1, 32'hDEAD_BEEF, 4'hF, 3, 1, 0, 32'h0);
    endtask

    task automatic test_resp_backpressure;
        run_txn(1, 0, 32'h8000_0040, 32'h0, 0, 32'h0, 4'h0, 1, 0, 4, 32'hCAFE_F00D);
        run_txn(0, 1, 32'h0, 32'h8000_2000, 0, 32'h0, 4'h0, 0, 1, 4, 32'h1357_9BDF);
    endtask

    task automatic test_reset_mid;
        clear_inputs();
        lsu_req_valid = 1; lsu_addr = 32'h8000_3000;
        tick;
        clear_inputs();
        mem_req_ready = 1;
        tick;
        clear_inputs();
        mem_resp_valid = 1; mem_rdata = 32'h5555_AAAA;
        #1;
        n_tests++;
        if (lsu_resp_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_in_resp: got lsu_rv %b want 1", lsu_resp_valid);
        end
        rst = 1; ifu_req_valid = 1; lsu_req_valid = 1;
        tick;
        n_tests++;
        if ({ifu_req_ready, lsu_req_ready, mem_req_valid, mem_resp_ready, ifu_resp_valid, lsu_resp_valid,
             mem_addr, mem_wdata, mem_wmask, mem_wen} !== '0) begin
            n_fail++;
            $display("FAIL mid_reset_out: got rdy %b%b mrv %b mrr %b rv %b%b a=%h d=%h m=%h w=%b want all 0",
                     ifu_req_ready, lsu_req_ready, mem_req_valid, mem_resp_ready, ifu_resp_valid,
                     lsu_resp_valid, mem_addr, mem_wdata, mem_wmask, mem_wen);
        end
        rst = 0; m_last = 1'b1;
        ifu_req_valid = 0; lsu_req_valid = 0; lsu_resp_ready = 1;
        #1;
        n_tests++;
        if ({lsu_resp_valid, mem_resp_ready} !== 2'b00) begin
            n_fail++;
            $display("FAIL mid_no_resp: got lsu_rv %b mrr %b want 00", lsu_resp_valid, mem_resp_ready);
        end
        clear_inputs();
        run_txn(1, 1, 32'h8000_0100, 32'h8000_0200, 1, 32'h0bad_0bad, 4'h3, 0, 0, 0, 32'h7777_0000);
    endtask

    task automatic test_random;
        for (int unsigned k = 0; k < 30; k++) begin
            logic iv, lv;
            iv = 1'($urandom_range(0, 1));
            lv = iv ? 1'($urandom_range(0, 1)) : 1'b1;
            run_txn(iv, lv, $urandom, $urandom, 1'($urandom_range(0, 1)), $urandom, 4'($urandom),
                    $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), $urandom);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion want finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_single_fetch();
        test_round_robin();
        test_store_stall();
        test_resp_backpressure();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
Parameters:
REQ-001 SHALL have ADDR_W, default 32, address width.
REQ-002 SHALL have DATA_W, default 32, data width; wmask width is DATA_W/8.
Ports (name direction width meaning):
REQ-003 SHALL have clk in 1: the single clock, all state updates on rising edge.
REQ-004 SHALL have rst in 1: synchronous, active-high reset.
REQ-005 SHALL have ifu_req_valid in 1, ifu_req_ready out 1, ifu_addr in ADDR_W: fetch request channel, read-only.
REQ-006 SHALL have ifu_resp_valid out 1, ifu_resp_ready in 1, ifu_rdata out DATA_W: fetch response channel.
REQ-007 SHALL have lsu_req_valid in 1, lsu_req_ready out 1, lsu_addr in ADDR_W, lsu_wen in 1, lsu_wdata in DATA_W, lsu_wmask in DATA_W/8: load/store request channel.
REQ-008 SHALL have lsu_resp_valid out 1, lsu_resp_ready in 1, lsu_rdata out DATA_W: load/store response channel; stores also return one response.
REQ-009 SHALL have mem_req_valid out 1, mem_req_ready in 1, mem_addr out ADDR_W, mem_wen out 1, mem_wdata out DATA_W, mem_wmask out DATA_W/8: shared memory request channel.
REQ-010 SHALL have mem_resp_valid in 1, mem_resp_ready out 1, mem_rdata in DATA_W: shared memory response channel.

Function
REQ-011 SHALL implement FSM states IDLE, REQ, RESP plus a 1-bit owner register (0=IFU, 1=LSU) and a 1-bit last-grant register.
REQ-012 SHALL, in IDLE with at least one req_valid, grant exactly one master: if only one is valid grant it; if both valid grant the master not equal to last-grant (round-robin).
REQ-013 SHALL assert the granted master's req_ready for exactly that IDLE cycle (combinational from valids and last-grant) and never assert req_ready outside IDLE.
REQ-014 SHALL, on the grant edge, capture addr, wen, wdata, wmask of the granted master into holding registers, set owner and last-grant to the granted master, move to REQ.
REQ-015 SHALL force captured wen=0, wmask=0, wdata=0 when the IFU is granted.
REQ-016 SHALL, in REQ, drive mem_req_valid=1 and mem_addr/wen/wdata/wmask from holding registers, stable until mem_req_ready=1; on that edge move to RESP.
REQ-017 SHALL drive mem_req_valid=0 in IDLE and RESP.
REQ-018 SHALL, in RESP, route mem_resp_valid and mem_rdata to the owner's resp channel combinationally, drive mem_resp_ready from the owner's resp_ready, and hold the non-owner's resp_valid at 0.
REQ-019 SHALL leave RESP for IDLE on the edge where mem_resp_valid and owner resp_ready are both 1.
REQ-020 SHALL drive mem_resp_ready=0 and both resp_valid=0 outside RESP.
REQ-021 SHALL have minimum latency from request acceptance to mem_req_valid of 1 cycle; a new grant cannot occur in the cycle a response completes (one IDLE cycle between transactions).
REQ-022 SHALL ignore req_valid changes while not in IDLE; a master deasserting req_valid before grant is simply not granted.
REQ-023 SHALL stall indefinitely in REQ/RESP if the memory or owner never handshakes; no timeout.

Reset
REQ-024 SHALL, when rst=1 at a rising edge, enter IDLE, set owner=0, last-grant=1 (IFU wins the first tie), clear holding registers to 0.
REQ-025 SHALL, while in reset state, drive all ready/valid outputs 0 and all data/addr/mask outputs 0.
REQ-026 SHALL on reset mid-transaction (REQ or RESP) abandon it without issuing a response; the memory side is reset by the same rst.

Verification
REQ-027 Single IFU fetch addr=0x80000000, mem ready and resp after 2 cycles, rdata=0x00000413 -> ifu_req_ready 1 cycle, mem_req_valid next cycle, mem_wen=0, ifu_resp_valid with rdata 0x00000413, return to IDLE.
REQ-028 IFU and LSU valid together from reset -> IFU granted first; after completion both still valid -> LSU granted; third tie -> IFU.
REQ-029 LSU store addr=0x80001000, wdata=0xDEADBEEF, wmask=0xF, mem_req_ready low 3 cycles -> mem_addr/wdata/wmask held constant throughout REQ, lsu_resp_valid on response, ifu_resp_valid stays 0.
REQ-030 Owner resp_ready held 0 for 4 cycles while mem_resp_valid=1 -> mem_resp_ready=0, FSM stays RESP, exits on the ready cycle.
REQ-031 rst asserted during RESP -> next cycle IDLE, all outputs 0, no resp_valid; subsequent tie grants IFU.
